input_frame_sequencer: RTL

Parametrised input-side frame sequencer for the FFT processor. It accepts samples over a valid/ready handshake and generates the write address and write enable for the input buffer. It fires a one-cycle `mastertrig_o` pulse a programmable number of samples before the frame ends, so downstream butterfly stages can pre-arm. It supports N = 2^LOG2N points, stalls on gaps in `in_valid`, runs frames back-to-back, and flags overruns.

---
 rtl/input_frame_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/input_frame_sequencer.sv
// ----------------------------------------------------------------------------
// input_frame_sequencer
//
// Input-side frame sequencer for the FFT processor. Accepts samples over a
// valid/ready handshake and produces the input-buffer write address and write
// enable. A one-cycle pre-arm pulse (mastertrig_o) fires a programmable number
// of samples before the end of each frame so later butterfly stages can get
// ready. Gaps in in_valid stall the address, frames can run back-to-back, and
// samples offered while not ready raise a sticky overrun flag.
//
// Parameters
//   LOG2N        log2 of the frame length N (2..12)
//   TRIG_OFFSET  pulse follows the accept of index N-1-TRIG_OFFSET (0..N-1)
//   CONTINUOUS   1: start the next frame automatically after the last sample
//
// Ports
//   clk            in   clock, rising edge
//   rst            in   synchronous, active-high reset
//   start          in   level-sampled frame start request
//   in_valid       in   upstream sample valid
//   in_ready       out  sequencer can accept (state == RUN)
//   wr_en_o        out  buffer write enable (in_valid & in_ready)
//   addr_o         out  registered write address / index of offered sample
//   frame_last_o   out  write of the final sample of the frame
//   mastertrig_o   out  registered one-cycle pre-arm pulse
//   busy_o         out  registered, high while in RUN
//   frame_cnt_o    out  registered count of completed frames (wraps at 256)
//   clear_overrun  in   clears the sticky overrun flag
//   overrun_o      out  registered sticky overrun flag
// ----------------------------------------------------------------------------
module input_frame_sequencer #(
    parameter int LOG2N       = 6,
    parameter int TRIG_OFFSET = 10,
    parameter bit CONTINUOUS  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             wr_en_o,
    output logic [LOG2N-1:0] addr_o,
    output logic             frame_last_o,
    output logic             mastertrig_o,
    output logic             busy_o,
    output logic [7:0]       frame_cnt_o,
    input  logic             clear_overrun,
    output logic             overrun_o
);

    localparam int N = 1 << LOG2N;
    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);
    localparam logic [LOG2N-1:0] TRIG_IDX = LOG2N'(N - 1 - TRIG_OFFSET);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [LOG2N-1:0] addr_q, addr_d;
    logic             trig_q, trig_d;
    logic             busy_q, busy_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             ovr_q, ovr_d;

    logic accept;
    logic last;

    assign in_ready     = (state_q == RUN);
    assign accept       = in_valid & in_ready;
    assign last         = accept && (addr_q == LAST_IDX);

    assign wr_en_o      = accept;
    assign addr_o       = addr_q;
    assign frame_last_o = last;
    assign mastertrig_o = trig_q;
    assign busy_o       = busy_q;
    assign frame_cnt_o  = cnt_q;
    assign overrun_o    = ovr_q;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path can
        // leave it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                addr_d = '0;
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // Natural LOG2N-bit overflow gives the exact wrap at N.
                if (accept) begin
                    addr_d = addr_q + LOG2N'(1);
                end
                // start only matters on the last sample: it chains the next
                // frame with no bubble, it never realigns the current one.
                if (last) begin
                    cnt_d = cnt_q + 8'd1;
                    if (!(CONTINUOUS || start)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Gated by accept so a stall sitting on the trigger index waits for
        // the real sample, giving exactly one pulse per frame.
        trig_d = accept && (addr_q == TRIG_IDX);

        // Registered copy of the state: follows the state register exactly.
        busy_d = (state_d == RUN);

        // Set has priority over clear so a coincident overrun is not lost.
        if (in_valid && !in_ready) begin
            ovr_d = 1'b1;
        end else if (clear_overrun) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the values
        // from before the edge, independent of statement order.
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            trig_q  <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= 8'd0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            trig_q  <= trig_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
        end
    end

endmodule
